lock_controller: RTL and testbench
==================================

LOCK_CONTROLLER -- requirements
Module: lock_controller

Interface
REQ-001 Parameter CODE_LEN, default 4: number of BCD digits per code (legal 1..8).
REQ-002 Parameter DEFAULT_CODE, default 32'h0000_1234: reset code, low CODE_LEN nibbles used, last-entered digit in nibble 0.
REQ-003 Parameter MAX_TRIES, default 3: consecutive failures that trigger lockout (legal 1..7).
REQ-004 Parameter LOCKOUT_TICKS, default 30: lockout duration in slow ticks (legal 1..255).
REQ-005 Parameter UNLOCK_TICKS, default 5: auto-relock delay in slow ticks (legal 1..255).
REQ-006 clk  in  1  system clock; single clock domain, every register on posedge clk.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 slow_clk  in  1  divided square wave from the clock divider; asynchronous to any logic decision, used only as a tick source.
REQ-009 digit_valid  in  1  one-clk strobe qualifying digit.
REQ-010 digit  in  4  BCD digit 0..9; values 10..15 are rejected.
REQ-011 clear  in  1  one-clk strobe; aborts the current entry.
REQ-012 prog  in  1  one-clk strobe; requests code reprogramming (see Configuration).
REQ-013 unlocked  out  1  high while in UNLOCKED.
REQ-014 lockout  out  1  high while in LOCKOUT.
REQ-015 err  out  1  one-clk pulse on a wrong code or an invalid digit.
REQ-016 entry_cnt  out  4  digits accepted in the current entry.
REQ-017 fail_cnt  out  3  consecutive failures.
REQ-018 ticks_left  out  8  remaining ticks in UNLOCKED/LOCKOUT, else 0.

Function
REQ-019 slow_clk SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized value SHALL produce a one-clk internal tick, 3 clks after the edge (at most one tick per slow_clk period).
REQ-020 States: IDLE, ENTRY, CHECK, UNLOCKED, LOCKOUT, and PROG when enabled.
REQ-021 IDLE/ENTRY: a valid digit shifts into the entry register (nibble 0 newest), increments entry_cnt, and moves to ENTRY.
REQ-022 Digit > 9: err pulse the next clk; the entry is discarded, entry_cnt returns to 0, the state returns to IDLE, and fail_cnt is unchanged.
REQ-023 When entry_cnt reaches CODE_LEN: go to CHECK; no further digits are accepted until the compare resolves.
REQ-024 CHECK lasts exactly one clk. Match: go to UNLOCKED, fail_cnt=0, ticks_left=UNLOCK_TICKS. Mismatch: err pulse, fail_cnt+1; go to LOCKOUT with ticks_left=LOCKOUT_TICKS if fail_cnt reaches MAX_TRIES, otherwise go to IDLE.
REQ-025 In UNLOCKED/LOCKOUT, each tick decrements ticks_left; the tick that reaches 0 returns the FSM to IDLE on the same clk. On leaving LOCKOUT, fail_cnt=0.
REQ-026 In CHECK, UNLOCKED and LOCKOUT, digit_valid and clear are ignored.
REQ-027 clear in ENTRY: entry_cnt=0, go to IDLE; no err, no fail count. clear in IDLE has no effect.
REQ-028 Same-clk digit_valid and clear: clear wins and the digit is dropped.
REQ-029 Same-clk tick and any keypad strobe: the two are handled independently.
REQ-030 entry_cnt SHALL never exceed CODE_LEN; fail_cnt saturates at MAX_TRIES; ticks_left never wraps below 0.

Reset
REQ-031 On rst: state=IDLE; unlocked=0, lockout=0, err=0, entry_cnt=0, fail_cnt=0, ticks_left=0; stored code=DEFAULT_CODE; synchronizer and edge flops=0.
REQ-032 rst asserted mid-operation, including during UNLOCKED or LOCKOUT, SHALL abort immediately with no residual timer or failure history.

Configuration
REQ-033 Macro LOCK_PROGRAM_EN defined: prog in UNLOCKED goes to PROG. In PROG, CODE_LEN valid digits replace the stored code, then the FSM goes to IDLE. clear or an invalid digit in PROG keeps the old code, goes to IDLE, and pulses err only for an invalid digit. No tick timeout applies in PROG; unlocked=0 in PROG.
REQ-034 LOCK_PROGRAM_EN undefined: no PROG state, prog ignored, stored code is the constant DEFAULT_CODE.

Verification
REQ-035 Reset, then digits 1,2,3,4 -> unlocked=1 two clks after the 4th strobe, ticks_left=5; after 5 ticks, unlocked=0 and state IDLE.
REQ-036 Three entries of 9,9,9,9 -> err pulses three times, fail_cnt 1,2,3; lockout=1 with ticks_left=30; digits ignored; after 30 ticks, lockout=0 and fail_cnt=0.
REQ-037 Digits 1,2 then clear, then 1,2,3,4 -> unlocked=1, no err pulse, fail_cnt=0.
REQ-038 Digit 4'hB mid-entry -> err pulse, entry_cnt=0, fail_cnt unchanged; digit_valid and clear on the same clk -> digit dropped.
REQ-039 With LOCK_PROGRAM_EN: unlock, prog, 5,6,7,8 -> then 1,2,3,4 fails and 5,6,7,8 unlocks; after rst, 1,2,3,4 unlocks again.
REQ-040 rst asserted during LOCKOUT with ticks_left=17 -> all outputs at reset values asynchronously; 1,2,3,4 then unlocks.

Source files
------------

// File: rtl/lock_controller_if.sv
// Keypad and status bundle for lock_controller: the keypad drives the strobes,
// the controller drives the status outputs.
interface lock_controller_if;
    logic       digit_valid;
    logic [3:0] digit;
    logic       clear;
    logic       prog;
    logic       unlocked;
    logic       lockout;
    logic       err;
    logic [3:0] entry_cnt;
    logic [2:0] fail_cnt;
    logic [7:0] ticks_left;

    modport master (
        output digit_valid, digit, clear, prog,
        input  unlocked, lockout, err, entry_cnt, fail_cnt, ticks_left
    );

    modport slave (
        input  digit_valid, digit, clear, prog,
        output unlocked, lockout, err, entry_cnt, fail_cnt, ticks_left
    );
endinterface

// File: rtl/lock_controller.sv
// BCD keypad lock with retry lockout and timed auto-relock.
// Optional macro LOCK_PROGRAM_EN adds a PROG state for replacing the stored code.
module lock_controller #(
    parameter int unsigned CODE_LEN      = 4,
    parameter logic [31:0] DEFAULT_CODE  = 32'h0000_1234,
    parameter int unsigned MAX_TRIES     = 3,
    parameter int unsigned LOCKOUT_TICKS = 30,
    parameter int unsigned UNLOCK_TICKS  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              slow_clk,
    lock_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        UNLOCKED,
        LOCKOUT
`ifdef LOCK_PROGRAM_EN
        , PROG
`endif
    } state_t;

    localparam logic [3:0]  LEN      = 4'(CODE_LEN);
    localparam logic [2:0]  TRIES    = 3'(MAX_TRIES);
    localparam logic [7:0]  LOCK_T   = 8'(LOCKOUT_TICKS);
    localparam logic [7:0]  UNLOCK_T = 8'(UNLOCK_TICKS);
    localparam logic [31:0] CODE_MASK =
        (CODE_LEN >= 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * CODE_LEN)) - 32'd1);

    state_t      state;
    logic [31:0] entry;
    logic [31:0] code;
    logic [3:0]  entry_count;
    logic [2:0]  fail_count;
    logic [7:0]  tick_count;
    logic        unlock_flag;
    logic        lock_flag;
    logic        err_flag;

    logic        sync1, sync2, sync_prev, tick;

    logic [31:0] entry_next;
    logic [3:0]  count_next;
    logic [2:0]  fail_next;
    logic        digit_bad;
    logic        code_match;

    assign entry_next = {entry[27:0], bus.digit};
    assign count_next = entry_count + 4'd1;
    assign fail_next  = fail_count + 3'd1;
    assign digit_bad  = (bus.digit > 4'd9);
    assign code_match = ((entry & CODE_MASK) == (code & CODE_MASK));

`ifndef LOCK_PROGRAM_EN
    logic unused_prog;
    assign code        = DEFAULT_CODE;
    assign unused_prog = bus.prog;
`endif

    // Tick is registered so it lands three clks after the slow_clk edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
            tick      <= 1'b0;
        end else begin
            sync1     <= slow_clk;
            sync2     <= sync1;
            sync_prev <= sync2;
            tick      <= sync2 & ~sync_prev;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            entry       <= '0;
            entry_count <= '0;
            fail_count  <= '0;
            tick_count  <= '0;
            unlock_flag <= 1'b0;
            lock_flag   <= 1'b0;
            err_flag    <= 1'b0;
`ifdef LOCK_PROGRAM_EN
            code        <= DEFAULT_CODE;
`endif
        end else begin
            err_flag <= 1'b0;
            case (state)
                IDLE, ENTRY: begin
                    if (bus.clear) begin
                        entry_count <= '0;
                        state       <= IDLE;
                    end else if (bus.digit_valid) begin
                        if (digit_bad) begin
                            err_flag    <= 1'b1;
                            entry_count <= '0;
                            state       <= IDLE;
                        end else begin
                            entry       <= entry_next;
                            entry_count <= count_next;
                            state       <= (count_next == LEN) ? CHECK : ENTRY;
                        end
                    end
                end

                CHECK: begin
                    entry_count <= '0;
                    if (code_match) begin
                        state       <= UNLOCKED;
                        unlock_flag <= 1'b1;
                        fail_count  <= '0;
                        tick_count  <= UNLOCK_T;
                    end else begin
                        err_flag <= 1'b1;
                        if (fail_next >= TRIES) begin
                            state      <= LOCKOUT;
                            lock_flag  <= 1'b1;
                            fail_count <= TRIES;
                            tick_count <= LOCK_T;
                        end else begin
                            state      <= IDLE;
                            fail_count <= fail_next;
                        end
                    end
                end

                UNLOCKED: begin
`ifdef LOCK_PROGRAM_EN
                    if (bus.prog) begin
                        state       <= PROG;
                        unlock_flag <= 1'b0;
                        tick_count  <= '0;
                        entry_count <= '0;
                    end else
`endif
                    if (tick) begin
                        if (tick_count <= 8'd1) begin
                            state       <= IDLE;
                            unlock_flag <= 1'b0;
                            tick_count  <= '0;
                        end else begin
                            tick_count <= tick_count - 8'd1;
                        end
                    end
                end

                LOCKOUT: begin
                    if (tick) begin
                        if (tick_count <= 8'd1) begin
                            state      <= IDLE;
                            lock_flag  <= 1'b0;
                            tick_count <= '0;
                            fail_count <= '0;
                        end else begin
                            tick_count <= tick_count - 8'd1;
                        end
                    end
                end

`ifdef LOCK_PROGRAM_EN
                PROG: begin
                    if (bus.clear) begin
                        entry_count <= '0;
                        state       <= IDLE;
                    end else if (bus.digit_valid) begin
                        if (digit_bad) begin
                            err_flag    <= 1'b1;
                            entry_count <= '0;
                            state       <= IDLE;
                        end else if (count_next == LEN) begin
                            code        <= entry_next;
                            entry_count <= '0;
                            state       <= IDLE;
                        end else begin
                            entry       <= entry_next;
                            entry_count <= count_next;
                        end
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.unlocked   = unlock_flag;
    assign bus.lockout    = lock_flag;
    assign bus.err        = err_flag;
    assign bus.entry_cnt  = entry_count;
    assign bus.fail_cnt   = fail_count;
    assign bus.ticks_left = tick_count;

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller: a keypad-level reference model checked
// every clock, plus literal expectations at key points of each scenario.
module tb_lock_controller;

    localparam int          LEN   = 4;
    localparam logic [31:0] DEF   = 32'h0000_1234;
    localparam int          TRIES = 3;
    localparam int          LOCKT = 30;
    localparam int          UNLT  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic slow_clk = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    lock_controller_if bus ();

    lock_controller #(
        .CODE_LEN      (LEN),
        .DEFAULT_CODE  (DEF),
        .MAX_TRIES     (TRIES),
        .LOCKOUT_TICKS (LOCKT),
        .UNLOCK_TICKS  (UNLT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .slow_clk (slow_clk),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // slow_clk period is 8 clks, edges kept well away from posedge clk
    initial begin
        #2;
        forever #40 slow_clk = ~slow_clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, got running, required finished");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model (keypad-level) ----------------
    int          m_q[$];
    bit          m_check, m_unl, m_lko, m_err, m_prog, m_tick;
    int          m_fail, m_timer;
    logic [31:0] m_code = DEF;
    logic [31:0] m_val;
    logic [3:0]  m_hist = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_check = 0; m_unl = 0; m_lko = 0; m_err = 0; m_prog = 0;
            m_fail = 0; m_timer = 0; m_code = DEF; m_hist = '0;
        end else begin
            // a slow_clk rise first sampled 3 edges ago takes effect now
            m_tick = m_hist[2] & ~m_hist[3];
            m_hist = {m_hist[2:0], slow_clk};
            m_err = 0;
            if (m_check) begin
                m_val = 0;
                foreach (m_q[i]) m_val = m_val * 16 + 32'(m_q[i]);
                m_q.delete();
                m_check = 0;
                if (m_val == (m_code & 32'h0000_FFFF)) begin
                    m_unl = 1; m_timer = UNLT; m_fail = 0;
                end else begin
                    m_err = 1;
                    m_fail = m_fail + 1;
                    if (m_fail == TRIES) begin m_lko = 1; m_timer = LOCKT; end
                end
            end else if (m_unl) begin
`ifdef LOCK_PROGRAM_EN
                if (bus.prog) begin
                    m_unl = 0; m_timer = 0; m_prog = 1; m_q.delete();
                end else
`endif
                if (m_tick) begin
                    m_timer = m_timer - 1;
                    if (m_timer == 0) m_unl = 0;
                end
            end else if (m_lko) begin
                if (m_tick) begin
                    m_timer = m_timer - 1;
                    if (m_timer == 0) begin m_lko = 0; m_fail = 0; end
                end
            end else if (bus.clear) begin
                m_q.delete(); m_prog = 0;
            end else if (bus.digit_valid) begin
                if (bus.digit > 9) begin
                    m_err = 1; m_q.delete(); m_prog = 0;
                end else begin
                    m_q.push_back(int'(bus.digit));
                    if (m_q.size() == LEN) begin
                        if (m_prog) begin
                            m_val = 0;
                            foreach (m_q[i]) m_val = m_val * 16 + 32'(m_q[i]);
                            m_code = m_val;
                            m_q.delete();
                            m_prog = 0;
                        end else begin
                            m_check = 1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("m_unlocked",   int'(bus.unlocked),   int'(m_unl));
        check("m_lockout",    int'(bus.lockout),    int'(m_lko));
        check("m_err",        int'(bus.err),        int'(m_err));
        check("m_entry_cnt",  int'(bus.entry_cnt),  m_q.size());
        check("m_fail_cnt",   int'(bus.fail_cnt),   m_fail);
        check("m_ticks_left", int'(bus.ticks_left), m_timer);
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [3:0] d);
        bus.digit = d;
        bus.digit_valid = 1'b1;
        @(negedge clk);
        bus.digit_valid = 1'b0;
    endtask

    task automatic enter(input logic [15:0] c);
        press(c[15:12]); press(c[11:8]); press(c[7:4]); press(c[3:0]);
    endtask

    task automatic wait_rest(input string name);
        for (int i = 0; i < 600; i++) begin
            if (!bus.unlocked && !bus.lockout) break;
            @(negedge clk);
        end
        check(name, int'(bus.unlocked | bus.lockout), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_unlocked"},   int'(bus.unlocked),   0);
        check({tag, "_lockout"},    int'(bus.lockout),    0);
        check({tag, "_err"},        int'(bus.err),        0);
        check({tag, "_entry_cnt"},  int'(bus.entry_cnt),  0);
        check({tag, "_fail_cnt"},   int'(bus.fail_cnt),   0);
        check({tag, "_ticks_left"}, int'(bus.ticks_left), 0);
    endtask

    initial begin
        bus.digit_valid = 1'b0;
        bus.digit = 4'd0;
        bus.clear = 1'b0;
        bus.prog = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // correct code unlocks two clks after the last strobe, then relocks
        enter(16'h1234);
        check("unlock_entry_cnt_in_check", int'(bus.entry_cnt), 4);
        @(negedge clk);
        check("unlock_unlocked", int'(bus.unlocked), 1);
        check("unlock_ticks", int'(bus.ticks_left), 5);
        wait_rest("relock_timeout");
        check("relock_ticks", int'(bus.ticks_left), 0);

        // three wrong entries lead to lockout
        for (int k = 1; k <= 3; k++) begin
            enter(16'h9999);
            @(negedge clk);
            check("wrong_err", int'(bus.err), 1);
            check("wrong_fail_cnt", int'(bus.fail_cnt), k);
        end
        check("lockout_on", int'(bus.lockout), 1);
        check("lockout_ticks", int'(bus.ticks_left), 30);
        enter(16'h1234);
        check("lockout_digits_ignored", int'(bus.entry_cnt), 0);
        check("lockout_still", int'(bus.lockout), 1);
        wait_rest("lockout_end_timeout");
        check("lockout_end_fail_cnt", int'(bus.fail_cnt), 0);

        // clear mid-entry, then the right code
        press(4'd1); press(4'd2);
        check("partial_entry_cnt", int'(bus.entry_cnt), 2);
        bus.clear = 1'b1; @(negedge clk); bus.clear = 1'b0;
        check("clear_entry_cnt", int'(bus.entry_cnt), 0);
        check("clear_no_err", int'(bus.err), 0);
        enter(16'h1234);
        @(negedge clk);
        check("after_clear_unlocked", int'(bus.unlocked), 1);
        check("after_clear_fail", int'(bus.fail_cnt), 0);
        wait_rest("after_clear_relock");

        // invalid digit keeps fail history; digit with clear is dropped
        enter(16'h5555);
        @(negedge clk);
        check("fail_one", int'(bus.fail_cnt), 1);
        press(4'd1); press(4'd2); press(4'hB);
        check("bad_digit_err", int'(bus.err), 1);
        check("bad_digit_entry_cnt", int'(bus.entry_cnt), 0);
        check("bad_digit_fail_kept", int'(bus.fail_cnt), 1);
        bus.clear = 1'b1; press(4'd7); bus.clear = 1'b0;
        check("dv_clear_dropped", int'(bus.entry_cnt), 0);
        check("dv_clear_no_err", int'(bus.err), 0);
        enter(16'h1234);
        @(negedge clk);
        check("recover_unlocked", int'(bus.unlocked), 1);
        check("recover_fail", int'(bus.fail_cnt), 0);
        wait_rest("recover_relock");

`ifdef LOCK_PROGRAM_EN
        enter(16'h1234);
        @(negedge clk);
        check("prog_pre_unlock", int'(bus.unlocked), 1);
        bus.prog = 1'b1; @(negedge clk); bus.prog = 1'b0;
        check("prog_unlocked_low", int'(bus.unlocked), 0);
        enter(16'h5678);
        check("prog_done_cnt", int'(bus.entry_cnt), 0);
        enter(16'h1234);
        @(negedge clk);
        check("prog_old_code_err", int'(bus.err), 1);
        enter(16'h5678);
        @(negedge clk);
        check("prog_new_code_unlock", int'(bus.unlocked), 1);
        wait_rest("prog_relock");
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        enter(16'h1234);
        @(negedge clk);
        check("prog_reset_code", int'(bus.unlocked), 1);
        wait_rest("prog_reset_relock");
`endif

        // reset asserted asynchronously in the middle of a lockout
        for (int k = 0; k < 3; k++) begin
            enter(16'h9999);
            @(negedge clk);
        end
        for (int i = 0; i < 400; i++) begin
            if (bus.ticks_left == 8'd17) break;
            @(negedge clk);
        end
        check("lockout_reach_17", int'(bus.ticks_left), 17);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        enter(16'h1234);
        @(negedge clk);
        check("post_rst_unlocked", int'(bus.unlocked), 1);
        check("post_rst_ticks", int'(bus.ticks_left), 5);
        wait_rest("post_rst_relock");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
